// File: rtl/alu_seq_n.sv
// rtl/alu_seq_n.sv - registered multi-cycle ALU with start/ready/valid handshake
// Single-cycle ops commit at accept; shifts and MUL iterate in BUSY before DONE.
module alu_seq_n #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);
  localparam int CW = SHW + 1;
  localparam logic [3:0] OP_ADD = 4'd0, OP_ADC = 4'd1, OP_SUB = 4'd2, OP_AND = 4'd3,
                         OP_OR  = 4'd4, OP_XOR = 4'd5, OP_NOR = 4'd6, OP_SRL = 4'd7,
                         OP_SLL = 4'd8, OP_SRA = 4'd9, OP_MUL = 4'd10, OP_SEXT = 4'd11,
                         OP_ZEXT = 4'd12, OP_ORBIT = 4'd13;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b, r_acc, r_result;
  logic [CW-1:0]    r_cnt;
  logic             r_zero, r_carry, r_overflow, r_illegal;

  logic             w_accept, w_shift, w_multi, w_arith, w_last;
  logic [WIDTH-1:0] w_bb, w_single_res, w_step_a, w_mul_next, w_busy_res;
  logic [WIDTH:0]   w_sum;
  logic             w_cin, w_ovf;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_shift  = (op == OP_SRL) || (op == OP_SLL) || (op == OP_SRA);
  assign w_multi  = (w_shift && (shamt != '0)) || (op == OP_MUL);
  assign w_arith  = (op == OP_ADD) || (op == OP_ADC) || (op == OP_SUB);
  assign w_last   = (r_cnt == CW'(1));

  // SUB is a + ~b + 1 so carry out means "no borrow"
  assign w_bb  = (op == OP_SUB) ? ~b : b;
  assign w_cin = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? r_carry : 1'b0);
  assign w_sum = {1'b0, a} + {1'b0, w_bb} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (a[WIDTH-1] == w_bb[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    w_single_res = '0;
    case (op)
      OP_ADD, OP_ADC, OP_SUB: w_single_res = w_sum[WIDTH-1:0];
      OP_AND:                 w_single_res = a & b;
      OP_OR:                  w_single_res = a | b;
      OP_XOR:                 w_single_res = a ^ b;
      OP_NOR:                 w_single_res = ~(a | b);
      OP_SRL, OP_SLL, OP_SRA: w_single_res = a;
      OP_SEXT:                w_single_res = {{(WIDTH-16){a[15]}}, a[15:0]};
      OP_ZEXT:                w_single_res = {{(WIDTH-16){1'b0}}, a[15:0]};
      OP_ORBIT:               w_single_res = {{(WIDTH-1){1'b0}}, |a};
      default:                w_single_res = '0;
    endcase
  end

  // MUL reuses the left-shift path to walk the multiplicand
  assign w_step_a   = (r_op == OP_SRL) ? (r_a >> 1) :
                      (r_op == OP_SRA) ? {r_a[WIDTH-1], r_a[WIDTH-1:1]} : (r_a << 1);
  assign w_mul_next = r_acc + (r_b[0] ? r_a : '0);
  assign w_busy_res = (r_op == OP_MUL) ? w_mul_next : w_step_a;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_multi ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ready   = (r_state == S_IDLE);
    valid   = (r_state == S_DONE);
    illegal = (r_state == S_DONE) && r_illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op <= '0; r_a <= '0; r_b <= '0; r_acc <= '0; r_cnt <= '0;
      r_result <= '0; r_zero <= 1'b0; r_carry <= 1'b0;
      r_overflow <= 1'b0; r_illegal <= 1'b0;
    end else if (w_accept) begin
      r_op  <= op;
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_cnt <= (op == OP_MUL) ? CW'(WIDTH) : CW'(shamt);
      if (!w_multi) begin
        r_result  <= w_single_res;
        r_zero    <= (w_single_res == '0);
        r_illegal <= (op >= 4'd14);
        if (w_arith) begin
          r_carry    <= w_sum[WIDTH];
          r_overflow <= w_ovf;
        end
      end
    end else if (r_state == S_BUSY) begin
      r_a   <= w_step_a;
      r_b   <= r_b >> 1;
      r_acc <= w_mul_next;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result  <= w_busy_res;
        r_zero    <= (w_busy_res == '0);
        r_illegal <= 1'b0;
      end
    end
  end

  assign result   = r_result;
  assign zero     = r_zero;
  assign carry    = r_carry;
  assign overflow = r_overflow;
endmodule

// File: tb/tb_alu_seq_n.sv
// tb/tb_alu_seq_n.sv - directed self-checking bench for alu_seq_n
module tb_alu_seq_n;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  op;
  logic [31:0] a, b, result;
  logic [4:0]  shamt;
  logic        ready, valid, zero, carry, overflow, illegal;
  int          n_tests = 0, n_fail = 0, lat, nvalid;

  alu_seq_n #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .shamt(shamt),
    .ready(ready), .valid(valid), .result(result), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op; lat counts cycles from the accept edge to the valid-high sample
  task automatic run_op(input logic [3:0] o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [4:0] sh, input bit hammer, output int l);
    int w;
    w = 0;
    while (!ready && w < 100) begin
      @(posedge clk); #1; w++;
    end
    op = o; a = aa; b = bb; shamt = sh; start = 1'b1;
    @(posedge clk); #1;
    start = hammer;
    l = 1;
    while (!valid && l < 100) begin
      @(posedge clk); #1; l++;
    end
    start = 1'b0;
    if (l >= 100) check("timeout", 64'(l), 64'd0);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] r, input logic z,
                         input logic c, input logic ov);
    check({tag, ".result"}, 64'(result), 64'(r));
    check({tag, ".zero"}, 64'(zero), 64'(z));
    check({tag, ".carry"}, 64'(carry), 64'(c));
    check({tag, ".overflow"}, 64'(overflow), 64'(ov));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst.ready", 64'(ready), 64'd1);
    check("rst.valid", 64'(valid), 64'd0);
    check("rst.illegal", 64'(illegal), 64'd0);
    chk_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);

    run_op(4'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 5'd0, 1'b0, lat);
    check("add.lat", 64'(lat), 64'd1);
    chk_out("add", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

    run_op(4'd0, 32'hFFFFFFFF, 32'h00000001, 5'd0, 1'b0, lat);
    chk_out("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
    run_op(4'd3, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0, 1'b0, lat);
    chk_out("and", 32'hF000F000, 1'b0, 1'b1, 1'b0);
    run_op(4'd1, 32'h0, 32'h0, 5'd0, 1'b0, lat);
    chk_out("adc", 32'h00000001, 1'b0, 1'b0, 1'b0);
    run_op(4'd3, 32'hFFFFFFFF, 32'h0000FFFF, 5'd0, 1'b0, lat);
    chk_out("and2", 32'h0000FFFF, 1'b0, 1'b0, 1'b0);

    run_op(4'd0, 32'h7FFFFFFF, 32'h00000001, 5'd0, 1'b0, lat);
    chk_out("add_ovf", 32'h80000000, 1'b0, 1'b0, 1'b1);
    run_op(4'd2, 32'h80000000, 32'h00000001, 5'd0, 1'b0, lat);
    chk_out("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);

    run_op(4'd4, 32'h0F0F0000, 32'h0000F0F0, 5'd0, 1'b0, lat);
    chk_out("or", 32'h0F0FF0F0, 1'b0, 1'b1, 1'b1);
    run_op(4'd5, 32'hA5A5A5A5, 32'hFFFF0000, 5'd0, 1'b0, lat);
    chk_out("xor", 32'h5A5AA5A5, 1'b0, 1'b1, 1'b1);
    run_op(4'd6, 32'h0, 32'h0, 5'd0, 1'b0, lat);
    chk_out("nor", 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);

    run_op(4'd7, 32'hA5A5A5A5, 32'h0, 5'd3, 1'b0, lat);
    check("srl.lat", 64'(lat), 64'd4);
    chk_out("srl", 32'h14B4B4B4, 1'b0, 1'b1, 1'b1);
    run_op(4'd9, 32'h80000000, 32'h0, 5'd4, 1'b0, lat);
    check("sra.lat", 64'(lat), 64'd5);
    chk_out("sra", 32'hF8000000, 1'b0, 1'b1, 1'b1);
    run_op(4'd8, 32'h12345678, 32'h0, 5'd0, 1'b0, lat);
    check("sll0.lat", 64'(lat), 64'd1);
    chk_out("sll0", 32'h12345678, 1'b0, 1'b1, 1'b1);
    run_op(4'd8, 32'h12345678, 32'h0, 5'd4, 1'b0, lat);
    check("sll4.lat", 64'(lat), 64'd5);
    chk_out("sll4", 32'h23456780, 1'b0, 1'b1, 1'b1);

    run_op(4'd10, 32'd12345, 32'd678, 5'd0, 1'b1, lat);
    check("mul.lat", 64'(lat), 64'd33);
    chk_out("mul", 32'd8369910, 1'b0, 1'b1, 1'b1);
    nvalid = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("mul.extra_valid", 64'(nvalid), 64'd0);
    run_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0, 1'b0, lat);
    chk_out("mul_wrap", 32'h00000001, 1'b0, 1'b1, 1'b1);

    run_op(4'd11, 32'h0000FEBF, 32'h0, 5'd0, 1'b0, lat);
    chk_out("sext16", 32'hFFFFFEBF, 1'b0, 1'b1, 1'b1);
    run_op(4'd12, 32'h0000FEBF, 32'h0, 5'd0, 1'b0, lat);
    chk_out("zext16", 32'h0000FEBF, 1'b0, 1'b1, 1'b1);
    run_op(4'd13, 32'h0, 32'h0, 5'd0, 1'b0, lat);
    chk_out("orbit0", 32'h0, 1'b1, 1'b1, 1'b1);
    run_op(4'd13, 32'h00100000, 32'h0, 5'd0, 1'b0, lat);
    chk_out("orbit1", 32'h00000001, 1'b0, 1'b1, 1'b1);

    run_op(4'd15, 32'h12345678, 32'h1, 5'd0, 1'b0, lat);
    check("op15.illegal", 64'(illegal), 64'd1);
    chk_out("op15", 32'h0, 1'b1, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("op15.illegal_drop", 64'(illegal), 64'd0);
    run_op(4'd0, 32'h1, 32'h1, 5'd0, 1'b0, lat);
    check("post_illegal", 64'(illegal), 64'd0);
    chk_out("add_after", 32'h2, 1'b0, 1'b0, 1'b0);
    run_op(4'd2, 32'h5, 32'h3, 5'd0, 1'b0, lat);
    chk_out("sub", 32'h2, 1'b0, 1'b1, 1'b0);

    op = 4'd10; a = 32'd7; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst.ready", 64'(ready), 64'd1);
    check("midrst.valid", 64'(valid), 64'd0);
    check("midrst.illegal", 64'(illegal), 64'd0);
    chk_out("midrst", 32'h0, 1'b0, 1'b0, 1'b0);
    nvalid = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid) nvalid++;
    end
    check("midrst.no_valid", 64'(nvalid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
